// File: rtl/rggen_bit_field_access_driver.sv
// Single-port bit-field access driver: command handshake -> one-cycle strobe -> response handshake.
// Optional write-verify readback (RGGEN_BIT_FIELD_WRITE_VERIFY_EN) flags writes the field did not take.
module rggen_bit_field_access_driver #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_write,
  input  logic [WIDTH-1:0] i_cmd_data,
  input  logic [WIDTH-1:0] i_cmd_mask,
  output logic             o_bf_valid,
  output logic             o_bf_write,
  output logic [WIDTH-1:0] o_bf_write_data,
  output logic [WIDTH-1:0] o_bf_write_mask,
  input  logic [WIDTH-1:0] i_bf_read_data,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_error
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    VERIFY  = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             write_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] rsp_data_q;
  logic [WIDTH-1:0] rsp_data_d;
  logic             cmd_fire;

  assign cmd_fire = i_cmd_valid && o_cmd_ready;

  // Command fields stay latched until the next acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
    end else if (cmd_fire) begin
      write_q <= i_cmd_write;
      data_q  <= i_cmd_data;
      mask_q  <= i_cmd_mask;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
    end
  end

`ifdef RGGEN_BIT_FIELD_WRITE_VERIFY_EN
  logic rsp_error_q;
  logic rsp_error_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_error_q <= 1'b0;
    end else begin
      rsp_error_q <= rsp_error_d;
    end
  end

  assign o_rsp_error = rsp_error_q;
`else
  assign o_rsp_error = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
`ifdef RGGEN_BIT_FIELD_WRITE_VERIFY_EN
    rsp_error_d = rsp_error_q;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (!write_q) begin
          rsp_data_d = i_bf_read_data;
`ifdef RGGEN_BIT_FIELD_WRITE_VERIFY_EN
          rsp_error_d = 1'b0;
`endif
          state_d = RESPOND;
        end else begin
`ifdef RGGEN_BIT_FIELD_WRITE_VERIFY_EN
          state_d = VERIFY;
`else
          rsp_data_d = '0;
          state_d    = RESPOND;
`endif
        end
      end
`ifdef RGGEN_BIT_FIELD_WRITE_VERIFY_EN
      VERIFY: begin
        // Only bits the write was allowed to touch take part in the comparison.
        rsp_data_d  = i_bf_read_data;
        rsp_error_d = ((i_bf_read_data ^ data_q) & mask_q) != '0;
        state_d     = RESPOND;
      end
`endif
      RESPOND: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_cmd_ready     = state_q == IDLE;
  assign o_bf_valid      = (state_q == ACCESS) || (state_q == VERIFY);
  assign o_bf_write      = (state_q == ACCESS) && write_q;
  assign o_bf_write_data = data_q;
  assign o_bf_write_mask = o_bf_write ? mask_q : '0;
  assign o_rsp_valid     = state_q == RESPOND;
  assign o_rsp_data      = rsp_data_q;

  // A stalled response must not change under the consumer.
  rsp_hold_stable: assert property (
    @(posedge i_clk) disable iff (!i_rst_n)
    (o_rsp_valid && !i_rsp_ready) |=> (o_rsp_valid && $stable(o_rsp_data) && $stable(o_rsp_error))
  );

endmodule

// File: tb/tb_rggen_bit_field_access_driver.sv
// Bench for rggen_bit_field_access_driver: drives a modelled lockable field and checks
// responses, strobes and latency against a behavioural reference of the access rules.
module tb_rggen_bit_field_access_driver;
  localparam int W = 8;
`ifdef RGGEN_BIT_FIELD_WRITE_VERIFY_EN
  localparam bit VERIFY_EN = 1'b1;
`else
  localparam bit VERIFY_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_write;
  logic [W-1:0] cmd_data;
  logic [W-1:0] cmd_mask;
  logic         bf_valid;
  logic         bf_write;
  logic [W-1:0] bf_wdata;
  logic [W-1:0] bf_wmask;
  logic [W-1:0] bf_rdata;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_data;
  logic         rsp_error;

  logic [W-1:0] field = '0;
  logic [W-1:0] junk = '0;
  logic         locked = 1'b0;
  logic         preset_en = 1'b0;
  logic [W-1:0] preset_val = '0;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  rggen_bit_field_access_driver #(.WIDTH(W)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_write     (cmd_write),
    .i_cmd_data      (cmd_data),
    .i_cmd_mask      (cmd_mask),
    .o_bf_valid      (bf_valid),
    .o_bf_write      (bf_write),
    .o_bf_write_data (bf_wdata),
    .o_bf_write_mask (bf_wmask),
    .i_bf_read_data  (bf_rdata),
    .o_rsp_valid     (rsp_valid),
    .i_rsp_ready     (rsp_ready),
    .o_rsp_data      (rsp_data),
    .o_rsp_error     (rsp_error)
  );

  // Lockable field; read data is garbage outside strobe cycles.
  assign bf_rdata = bf_valid ? field : junk;

  always @(posedge clk) begin
    if (preset_en) field <= preset_val;
    else if (bf_valid && bf_write && !locked) field <= (field & ~bf_wmask) | (bf_wdata & bf_wmask);
  end

  always @(negedge clk) junk <= W'($urandom);

  task automatic set_field(input logic [W-1:0] v);
    @(negedge clk);
    preset_val = v;
    preset_en  = 1'b1;
    @(negedge clk);
    preset_en  = 1'b0;
  endtask

  // Issues one command from IDLE (called at a negedge) and checks the whole transaction.
  task automatic run_cmd(input bit wr, input logic [W-1:0] d, input logic [W-1:0] m,
                         input int hold, input string tag);
    logic [W-1:0] old, newv, exp_data, got_data;
    bit exp_err, got_err;
    int exp_lat, exp_strobes, lat, nstrobe;
    old      = field;
    newv     = wr ? (locked ? old : ((old & ~m) | (d & m))) : old;
    exp_data = !wr ? old : (VERIFY_EN ? newv : '0);
    exp_err  = wr && VERIFY_EN && (((newv ^ d) & m) != 0);
    exp_lat  = (wr && VERIFY_EN) ? 3 : 2;
    exp_strobes = (wr && VERIFY_EN) ? 2 : 1;

    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready got=%b want=1", tag, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_data = d; cmd_mask = m;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = W'($urandom); cmd_mask = W'($urandom); cmd_write = 1'($urandom);
    lat = 1; nstrobe = 0;
    while (!rsp_valid && lat < 8) begin
      if (bf_valid) begin
        nstrobe++;
        checks++;
        if (nstrobe == 1 && {bf_write, bf_wmask, bf_wdata} !== {wr, (wr ? m : W'(0)), d}) begin
          errors++; $display("FAIL %s strobe1 got=%b/%h/%h want=%b/%h/%h", tag, bf_write, bf_wmask,
                             bf_wdata, wr, (wr ? m : W'(0)), d);
        end else if (nstrobe == 2 && {bf_write, bf_wmask} !== {1'b0, W'(0)}) begin
          errors++; $display("FAIL %s verify_strobe got=%b/%h want=0/00", tag, bf_write, bf_wmask);
        end
      end
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++; $display("FAIL %s busy_ready got=%b want=0", tag, cmd_ready);
      end
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != exp_lat || !rsp_valid) begin
      errors++; $display("FAIL %s latency got=%0d want=%0d", tag, lat, exp_lat);
    end
    checks++;
    if (nstrobe != exp_strobes) begin
      errors++; $display("FAIL %s strobes got=%0d want=%0d", tag, nstrobe, exp_strobes);
    end
    checks++;
    if (rsp_data !== exp_data || rsp_error !== exp_err || bf_valid !== 1'b0) begin
      errors++; $display("FAIL %s rsp got=%h/%b/%b want=%h/%b/0", tag, rsp_data, rsp_error,
                         bf_valid, exp_data, exp_err);
    end
    got_data = rsp_data; got_err = rsp_error;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if ({rsp_valid, cmd_ready, rsp_data, rsp_error} !== {1'b1, 1'b0, got_data, got_err}) begin
        errors++; $display("FAIL %s hold%0d got=%b/%b/%h/%b want=1/0/%h/%b", tag, i, rsp_valid,
                           cmd_ready, rsp_data, rsp_error, got_data, got_err);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01 || field !== newv) begin
      errors++; $display("FAIL %s done got=%b%b field=%h want=01 field=%h", tag, rsp_valid,
                         cmd_ready, field, newv);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_data = '0; cmd_mask = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({cmd_ready, bf_valid, bf_write, bf_wdata, bf_wmask, rsp_valid, rsp_data, rsp_error}
        !== {1'b1, 2'b00, W'(0), W'(0), 1'b0, W'(0), 1'b0}) begin
      errors++; $display("FAIL reset_values got=%b%b%b %h %h %b %h %b", cmd_ready, bf_valid,
                         bf_write, bf_wdata, bf_wmask, rsp_valid, rsp_data, rsp_error);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read;
    locked = 1'b0;
    set_field(8'hA5);
    run_cmd(1'b0, 8'h00, 8'h00, 0, "read_a5");
    checks++;
    if (rsp_data !== 8'hA5) begin
      errors++; $display("FAIL read_a5_held got=%h want=a5", rsp_data);
    end
  endtask

  task automatic test_write_verify;
    locked = 1'b0;
    set_field(8'h00);
    run_cmd(1'b1, 8'h3C, 8'hFF, 0, "write_unlocked");
    locked = 1'b1;
    set_field(8'h00);
    run_cmd(1'b1, 8'h3C, 8'hFF, 0, "write_locked");
    locked = 1'b0;
  endtask

  task automatic test_mask;
    set_field(8'h00);
    run_cmd(1'b1, 8'hFF, 8'h0F, 0, "mask_0f");
    checks++;
    if (field !== 8'h0F) begin
      errors++; $display("FAIL mask_0f_field got=%h want=0f", field);
    end
    run_cmd(1'b1, 8'hF0, 8'h00, 0, "mask_00");
  endtask

  task automatic test_backpressure;
    int n;
    set_field(8'h5A);
    run_cmd(1'b1, 8'hC3, 8'h3C, 5, "stall_write");
    // Second command waits behind a stalled response.
    cmd_valid = 1'b1; cmd_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, cmd_ready, bf_valid} !== 3'b100) begin
        errors++; $display("FAIL pending_cmd%0d got=%b%b%b want=100", i, rsp_valid, cmd_ready, bf_valid);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if ({rsp_valid, cmd_ready, bf_valid} !== 3'b010) begin
      errors++; $display("FAIL after_handshake got=%b%b%b want=010", rsp_valid, cmd_ready, bf_valid);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({bf_valid, bf_write, cmd_ready} !== 3'b100) begin
      errors++; $display("FAIL next_accept got=%b%b%b want=100", bf_valid, bf_write, cmd_ready);
    end
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    set_field(8'h99);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_data = 8'h66; cmd_mask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, bf_valid, bf_write, bf_wdata, bf_wmask, rsp_valid, rsp_data, rsp_error}
        !== {1'b1, 2'b00, W'(0), W'(0), 1'b0, W'(0), 1'b0}) begin
      errors++; $display("FAIL reset_in_access got=%b%b%b %h %h %b %h %b", cmd_ready, bf_valid,
                         bf_write, bf_wdata, bf_wmask, rsp_valid, rsp_data, rsp_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bf_valid, rsp_valid, field} !== {2'b00, 8'h99}) begin
        errors++; $display("FAIL post_reset_quiet got=%b%b %h want=00 99", bf_valid, rsp_valid, field);
      end
    end
    cmd_valid = 1'b1; cmd_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_ready, bf_valid, bf_write, bf_wdata, bf_wmask, rsp_valid, rsp_data, rsp_error}
        !== {1'b1, 2'b00, W'(0), W'(0), 1'b0, W'(0), 1'b0}) begin
      errors++; $display("FAIL reset_in_respond got=%b%b%b %h %h %b %h %b", cmd_ready, bf_valid,
                         bf_write, bf_wdata, bf_wmask, rsp_valid, rsp_data, rsp_error);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_cmd(1'b0, 8'h00, 8'h00, 0, "read_after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      locked = 1'($urandom);
      if ((i % 8) == 0) set_field(W'($urandom));
      run_cmd(1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, 3)), "random");
    end
    locked = 1'b0;
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_verify();
    test_mask();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule
